// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the sysid check controller.
package sysid_check_pkg;

   localparam int unsigned CNT_W = 16;

   localparam logic ADDR_ID = 1'b0;
   localparam logic ADDR_TS = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      RD_ID,
      WT_ID,
      RD_TS,
      WT_TS,
      FIN
   } state_t;

endpackage

// File: rtl/sysid_check_timer.sv
// Per-read response timer: counts enabled cycles since the last clear and
// flags expiry once the count reaches LIMIT-1.
module sysid_check_timer
   import sysid_check_pkg::*;
#(
   parameter logic [CNT_W-1:0] LIMIT = 16'd255
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] count;

   // Counter: clear has priority over increment.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + ONE;
      end
   end

   // >= rather than == so a count that passed LIMIT-1 on an accept edge
   // still expires during the following wait phase.
   assign expired = (count >= (LIMIT - ONE));

endmodule

// File: rtl/sysid_check_ctrl.sv
// Sysid check controller: reads the ID and timestamp words from an
// Avalon-MM sysid slave, compares them against the expected values and
// reports sticky result flags with a one-cycle done pulse.
module sysid_check_ctrl
   import sysid_check_pkg::*;
#(
   parameter logic [31:0]      EXP_ID         = 32'h0000_0000,
   parameter logic [31:0]      EXP_TIMESTAMP  = 32'd1486262794,
   parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 16'd255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout_err,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   state_t state;
   logic   tmr_clear;
   logic   tmr_enable;
   logic   tmr_expired;

   // Timer control: clear on entry to either read phase, run while a read
   // is outstanding.
   always_comb begin
      tmr_clear  = ((state == IDLE) && start) ||
                   ((state == WT_ID) && avm_readdatavalid);
      tmr_enable = (state == RD_ID) || (state == WT_ID) ||
                   (state == RD_TS) || (state == WT_TS);
   end

   sysid_check_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timer (
      .clock   (clock),
      .reset   (reset),
      .clear   (tmr_clear),
      .enable  (tmr_enable),
      .expired (tmr_expired)
   );

   // Check sequencer with registered bus strobes and result flags.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         avm_read    <= 1'b0;
         avm_address <= ADDR_ID;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         id_ok       <= 1'b0;
         ts_ok       <= 1'b0;
         timeout_err <= 1'b0;
         id_value    <= '0;
         ts_value    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state       <= RD_ID;
                  busy        <= 1'b1;
                  avm_read    <= 1'b1;
                  avm_address <= ADDR_ID;
                  pass        <= 1'b0;
                  id_ok       <= 1'b0;
                  ts_ok       <= 1'b0;
                  timeout_err <= 1'b0;
               end
            end
            RD_ID: begin
               if (!avm_waitrequest) begin
                  state    <= WT_ID;
                  avm_read <= 1'b0;
               end else if (tmr_expired) begin
                  state       <= FIN;
                  avm_read    <= 1'b0;
                  timeout_err <= 1'b1;
               end
            end
            WT_ID: begin
               if (avm_readdatavalid) begin
                  state       <= RD_TS;
                  id_value    <= avm_readdata;
                  id_ok       <= (avm_readdata == EXP_ID);
                  avm_read    <= 1'b1;
                  avm_address <= ADDR_TS;
               end else if (tmr_expired) begin
                  state       <= FIN;
                  timeout_err <= 1'b1;
               end
            end
            RD_TS: begin
               if (!avm_waitrequest) begin
                  state    <= WT_TS;
                  avm_read <= 1'b0;
               end else if (tmr_expired) begin
                  state       <= FIN;
                  avm_read    <= 1'b0;
                  timeout_err <= 1'b1;
               end
            end
            WT_TS: begin
               if (avm_readdatavalid) begin
                  state    <= FIN;
                  ts_value <= avm_readdata;
                  ts_ok    <= (avm_readdata == EXP_TIMESTAMP);
               end else if (tmr_expired) begin
                  state       <= FIN;
                  timeout_err <= 1'b1;
               end
            end
            FIN: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
               pass  <= id_ok & ts_ok & ~timeout_err;
            end
            default: begin
               state    <= IDLE;
               busy     <= 1'b0;
               avm_read <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Scoreboard bench for sysid_check_ctrl: a default-parameter instance and a
// TIMEOUT_CYCLES=8 instance share one directed slave stimulus.
module tb_sysid_check_ctrl;

   localparam logic [31:0] TS  = 32'd1486262794;
   localparam logic [31:0] BAD = 32'h5893_0000;

   typedef struct {
      int unsigned due;
      logic        p;
      logic        i;
      logic        t;
      logic        to;
      logic [31:0] iv;
      logic [31:0] tv;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        waitrequest;
   logic [31:0] readdata;
   logic        readdatavalid;

   logic        a_addr, a_read, a_busy, a_done, a_pass, a_id_ok, a_ts_ok, a_to;
   logic [31:0] a_idv, a_tsv;
   logic        b_addr, b_read, b_busy, b_done, b_pass, b_id_ok, b_ts_ok, b_to;
   logic [31:0] b_idv, b_tsv;

   int unsigned cyc = 0;
   int unsigned n_chk = 0;
   int unsigned n_pass = 0;
   int unsigned t0;
   exp_t        qa[$];
   exp_t        qb[$];
   exp_t        ea, eb;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   sysid_check_ctrl dut_a (
      .clock(clock), .reset(reset), .start(start),
      .avm_address(a_addr), .avm_read(a_read), .avm_waitrequest(waitrequest),
      .avm_readdata(readdata), .avm_readdatavalid(readdatavalid),
      .busy(a_busy), .done(a_done), .pass(a_pass), .id_ok(a_id_ok),
      .ts_ok(a_ts_ok), .timeout_err(a_to), .id_value(a_idv), .ts_value(a_tsv)
   );

   sysid_check_ctrl #(.TIMEOUT_CYCLES(16'd8)) dut_b (
      .clock(clock), .reset(reset), .start(start),
      .avm_address(b_addr), .avm_read(b_read), .avm_waitrequest(waitrequest),
      .avm_readdata(readdata), .avm_readdatavalid(readdatavalid),
      .busy(b_busy), .done(b_done), .pass(b_pass), .id_ok(b_id_ok),
      .ts_ok(b_ts_ok), .timeout_err(b_to), .id_value(b_idv), .ts_value(b_tsv)
   );

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic exp_t mk(input int unsigned due, input logic p, input logic i,
                               input logic t, input logic to,
                               input logic [31:0] iv, input logic [31:0] tv);
      exp_t e;
      e.due = due; e.p = p; e.i = i; e.t = t; e.to = to; e.iv = iv; e.tv = tv;
      return e;
   endfunction

   // Monitor for the default instance.
   always @(negedge clock) begin
      if (a_done) begin
         if (qa.size() == 0) begin
            check("a_spurious_done", a_done, 1'b0);
         end else begin
            ea = qa.pop_front();
            check("a_done_cycle", cyc, ea.due);
            check("a_result", {a_pass, a_id_ok, a_ts_ok, a_to, a_idv, a_tsv},
                  {ea.p, ea.i, ea.t, ea.to, ea.iv, ea.tv});
         end
      end
   end

   // Monitor for the short-timeout instance.
   always @(negedge clock) begin
      if (b_done) begin
         if (qb.size() == 0) begin
            check("b_spurious_done", b_done, 1'b0);
         end else begin
            eb = qb.pop_front();
            check("b_done_cycle", cyc, eb.due);
            check("b_result", {b_pass, b_id_ok, b_ts_ok, b_to, b_idv, b_tsv},
                  {eb.p, eb.i, eb.t, eb.to, eb.iv, eb.tv});
         end
      end
   end

   // Issue start; returns at the negedge after the sampling edge.
   task automatic start_check(output int unsigned t, input logic hold);
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1;
      t = cyc;
      if (!hold) start = 1'b0;
      @(negedge clock);
   endtask

   // Slave for one read: stall, accept, then data one cycle later.
   task automatic serve_read(input int unsigned stall, input logic [31:0] data, input logic addr);
      int unsigned n = 0;
      while (!a_read && n < 50) begin
         @(negedge clock);
         n++;
      end
      check("read_strobe_seen", {a_read, a_addr}, {1'b1, addr});
      waitrequest = (stall != 0);
      for (int unsigned i = 0; i < stall; i++) begin
         @(negedge clock);
         check("stall_hold", {a_read, a_addr}, {1'b1, addr});
      end
      waitrequest = 1'b0;
      @(negedge clock);
      readdatavalid = 1'b1;
      readdata      = data;
      @(negedge clock);
      readdatavalid = 1'b0;
      readdata      = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; start = 1'b0; waitrequest = 1'b0;
      readdata = '0; readdatavalid = 1'b0;
      repeat (3) @(negedge clock);
      check("reset_a", {a_addr, a_read, a_busy, a_done, a_pass, a_id_ok, a_ts_ok, a_to, a_idv, a_tsv}, '0);
      check("reset_b", {b_addr, b_read, b_busy, b_done, b_pass, b_id_ok, b_ts_ok, b_to, b_idv, b_tsv}, '0);
      reset = 1'b0;

      // Zero-wait check, all matching.
      start_check(t0, 1'b0);
      qa.push_back(mk(t0 + 5, 1, 1, 1, 0, 32'h0, TS));
      qb.push_back(mk(t0 + 5, 1, 1, 1, 0, 32'h0, TS));
      serve_read(0, 32'h0, 1'b0);
      serve_read(0, TS, 1'b1);
      repeat (3) @(negedge clock);

      // Three wait states per read.
      start_check(t0, 1'b0);
      qa.push_back(mk(t0 + 11, 1, 1, 1, 0, 32'h0, TS));
      qb.push_back(mk(t0 + 11, 1, 1, 1, 0, 32'h0, TS));
      serve_read(3, 32'h0, 1'b0);
      serve_read(3, TS, 1'b1);
      repeat (3) @(negedge clock);

      // Wrong timestamp.
      start_check(t0, 1'b0);
      qa.push_back(mk(t0 + 5, 0, 1, 0, 0, 32'h0, BAD));
      qb.push_back(mk(t0 + 5, 0, 1, 0, 0, 32'h0, BAD));
      serve_read(0, 32'h0, 1'b0);
      serve_read(0, BAD, 1'b1);
      repeat (3) @(negedge clock);

      // ID read never completes: both instances time out at their limits.
      start_check(t0, 1'b0);
      qa.push_back(mk(t0 + 256, 0, 0, 0, 1, 32'h0, BAD));
      qb.push_back(mk(t0 + 9, 0, 0, 0, 1, 32'h0, BAD));
      waitrequest = 1'b1;
      while (cyc < t0 + 258) begin
         @(negedge clock);
         if (cyc == t0 + 7) check("b_read_before_expiry", b_read, 1'b1);
         if (cyc == t0 + 8) check("b_read_after_expiry", b_read, 1'b0);
         if (cyc == t0 + 8) check("a_still_reading", a_read, 1'b1);
      end
      waitrequest = 1'b0;
      repeat (2) @(negedge clock);

      // Spurious readdatavalid in IDLE changes nothing.
      readdatavalid = 1'b1;
      readdata      = 32'hDEAD_BEEF;
      @(negedge clock);
      readdatavalid = 1'b0;
      readdata      = '0;
      @(negedge clock);
      check("idle_valid_a", {a_busy, a_pass, a_id_ok, a_ts_ok, a_to, a_idv, a_tsv},
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, BAD});
      check("idle_valid_b", {b_busy, b_pass, b_id_ok, b_ts_ok, b_to, b_idv, b_tsv},
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, BAD});

      // Start re-asserted while busy is ignored.
      start_check(t0, 1'b0);
      qa.push_back(mk(t0 + 5, 1, 1, 1, 0, 32'h0, TS));
      qb.push_back(mk(t0 + 5, 1, 1, 1, 0, 32'h0, TS));
      serve_read(0, 32'h0, 1'b0);
      start = 1'b1;
      serve_read(0, TS, 1'b1);
      start = 1'b0;
      repeat (3) @(negedge clock);
      check("no_restart", {a_busy, b_busy}, 2'b00);

      // Reset during WT_TS, then a clean check.
      start_check(t0, 1'b0);
      serve_read(0, 32'h0, 1'b0);
      waitrequest = 1'b0;
      @(negedge clock);
      check("in_wt_ts", {a_busy, a_read}, 2'b10);
      #2 reset = 1'b1;
      #1;
      check("async_reset_a", {a_addr, a_read, a_busy, a_done, a_pass, a_id_ok, a_ts_ok, a_to, a_idv, a_tsv}, '0);
      check("async_reset_b", {b_addr, b_read, b_busy, b_done, b_pass, b_id_ok, b_ts_ok, b_to, b_idv, b_tsv}, '0);
      @(negedge clock);
      reset         = 1'b0;
      readdatavalid = 1'b1;
      readdata      = TS;
      @(negedge clock);
      readdatavalid = 1'b0;
      readdata      = '0;
      @(negedge clock);
      check("late_valid_ignored", {a_busy, a_ts_ok, a_tsv}, '0);
      start_check(t0, 1'b0);
      qa.push_back(mk(t0 + 5, 1, 1, 1, 0, 32'h0, TS));
      qb.push_back(mk(t0 + 5, 1, 1, 1, 0, 32'h0, TS));
      serve_read(0, 32'h0, 1'b0);
      serve_read(0, TS, 1'b1);
      repeat (3) @(negedge clock);

      // Start held high through FIN launches a second check.
      start_check(t0, 1'b1);
      qa.push_back(mk(t0 + 5, 1, 1, 1, 0, 32'h0, TS));
      qb.push_back(mk(t0 + 5, 1, 1, 1, 0, 32'h0, TS));
      qa.push_back(mk(t0 + 11, 0, 1, 0, 0, 32'h0, 32'h1));
      qb.push_back(mk(t0 + 11, 0, 1, 0, 0, 32'h0, 32'h1));
      serve_read(0, 32'h0, 1'b0);
      serve_read(0, TS, 1'b1);
      serve_read(0, 32'h0, 1'b0);
      serve_read(0, 32'h1, 1'b1);
      start = 1'b0;
      repeat (5) @(negedge clock);

      check("a_queue_empty", qa.size(), 0);
      check("b_queue_empty", qb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sysid_check_ctrl.md
SYSID_CHECK_CTRL -- requirements
Module: sysid_check_ctrl

Interface
REQ-001 The block SHALL have parameter EXP_ID, default 32'h0000_0000, meaning the expected system ID word.
REQ-002 The block SHALL have parameter EXP_TIMESTAMP, default 32'd1486262794, meaning the expected build timestamp word.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 16'd255, meaning the per-read response limit in clocks, with a legal range of 1..65535.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: a check request, sampled in IDLE only.
REQ-007 The block SHALL have port avm_address, output, 1 bit: the sysid slave word select (0 = ID, 1 = timestamp).
REQ-008 The block SHALL have port avm_read, output, 1 bit: the Avalon-MM read strobe.
REQ-009 The block SHALL have port avm_waitrequest, input, 1 bit: the slave stall.
REQ-010 The block SHALL have port avm_readdata, input, 32 bits: the read data.
REQ-011 The block SHALL have port avm_readdatavalid, input, 1 bit: the read-data qualifier.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: a one-cycle pulse at check completion.
REQ-014 The block SHALL have ports pass, id_ok, ts_ok and timeout_err, outputs, 1 bit each: sticky result flags.
REQ-015 The block SHALL have ports id_value and ts_value, outputs, 32 bits each: the captured read words.

Function
REQ-016 The FSM SHALL use the states IDLE, RD_ID, WT_ID, RD_TS, WT_TS and FIN.
REQ-017 In IDLE, start=1 SHALL move the FSM to RD_ID on the next edge and clear pass, id_ok, ts_ok and timeout_err.
REQ-018 In RD_x, avm_read SHALL be 1 and avm_address SHALL be 0 for ID or 1 for TS; both SHALL be held stable while avm_waitrequest=1.
REQ-019 In RD_x, avm_waitrequest=0 SHALL accept the read and move the FSM to WT_x; avm_read SHALL be 0 in every other state.
REQ-020 In WT_x, avm_readdatavalid=1 SHALL capture avm_readdata into the matching *_value register, set the matching *_ok flag to (data == EXP_*), and advance WT_ID→RD_TS or WT_TS→FIN.
REQ-021 avm_readdatavalid outside WT_x SHALL be ignored, with no state or register change.
REQ-022 The timeout counter SHALL clear on entry to RD_ID and RD_TS and increment each cycle spent in RD_x or WT_x.
REQ-023 When the counter reaches TIMEOUT_CYCLES-1 without progress, the FSM SHALL set timeout_err, leave *_ok for unread words at 0, drop avm_read and go to FIN.
REQ-024 If progress (accept or valid) and expiry coincide, progress SHALL win.
REQ-025 In FIN, done SHALL be 1 for exactly one cycle, pass SHALL be set to id_ok & ts_ok & ~timeout_err, and the FSM SHALL return to IDLE next cycle.
REQ-026 start asserted while busy=1 SHALL be ignored; start held high through FIN SHALL begin a new check from IDLE.
REQ-027 Total latency with zero wait states and one-cycle readdatavalid latency SHALL be 5 cycles from the start edge to done.
REQ-028 Result flags and *_value SHALL hold until the next accepted start or reset.

Reset
REQ-029 Reset SHALL asynchronously force state=IDLE, the counter=0, avm_read=0, avm_address=0, busy=0, done=0, pass=0, id_ok=0, ts_ok=0, timeout_err=0, id_value=0 and ts_value=0.
REQ-030 Reset asserted mid-check SHALL abandon the transaction immediately, and any later avm_readdatavalid SHALL be ignored per REQ-021.

Structure
REQ-031 Package sysid_check_pkg SHALL hold the state enum, ADDR_ID=1'b0, ADDR_TS=1'b1 and the counter width constant (16).
REQ-032 The timeout counter SHALL be the single sub-module sysid_check_timer (inputs clear and enable; output expired).

Verification
REQ-033 A bench SHALL cover: default parameters, zero-wait slave returning 0 then 1486262794 → id_ok=1, ts_ok=1, pass=1, done exactly 5 cycles after start.
REQ-034 A bench SHALL cover: waitrequest held for 3 cycles on each read → address/read stable while stalled, pass=1, done at cycle 11.
REQ-035 A bench SHALL cover: timestamp returns 32'h5893_0000 → ts_ok=0, pass=0, ts_value=32'h5893_0000, timeout_err=0.
REQ-036 A bench SHALL cover: TIMEOUT_CYCLES=8 with no readdatavalid for the ID read → timeout_err=1, ts_ok=0, pass=0, done 9 cycles after start, avm_read=0 after expiry.
REQ-037 A bench SHALL cover: start pulsed while busy, plus a spurious readdatavalid in IDLE → no restart and no register change.
REQ-038 A bench SHALL cover: reset asserted during WT_TS → all outputs 0 asynchronously, and a subsequent start completes normally with pass=1.
